shared_mem_avmm_responder: RTL and testbench

//  Avalon-MM slave that terminates the HPS-side shared_mem_bridge master in the FPGA fabric.

---
 rtl/shmem_resp_pkg.sv | 18 +
 rtl/shared_mem_avmm_responder_if.sv | 29 ++
 rtl/shmem_resp_ram.sv | 29 ++
 rtl/shared_mem_avmm_responder.sv | 139 +++++++++++++
 tb/tb_shared_mem_avmm_responder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/shmem_resp_pkg.sv
// Shared constants, FSM state type and address helper for the shared-memory Avalon-MM responder.
package shmem_resp_pkg;

  localparam int DATA_W       = 32;
  localparam int BE_W         = 4;
  localparam int READ_LATENCY = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Byte address to word index; upper bits beyond the RAM depth alias.
  function automatic logic [31:0] addr_to_word(input logic [31:0] byte_addr, input int depth_log2);
    return (byte_addr >> 2) & ((32'd1 << depth_log2) - 32'd1);
  endfunction

endpackage

// File: rtl/shared_mem_avmm_responder_if.sv
// Avalon-MM slave bundle between the HPS shared_mem_bridge master and the responder.
// Handshake: a command (read or write) transfers on a clock edge where it is asserted and
// waitrequest is low; readdatavalid is an unthrottled one-cycle response pulse per accepted read.
interface shared_mem_avmm_responder_if #(
  parameter int ADDR_W = 18
) ();

  logic [ADDR_W-1:0]                   address;
  logic                                read;
  logic                                write;
  logic [shmem_resp_pkg::DATA_W-1:0]   writedata;
  logic [shmem_resp_pkg::BE_W-1:0]     byteenable;
  logic                                burstcount;
  logic                                debugaccess;
  logic                                waitrequest;
  logic [shmem_resp_pkg::DATA_W-1:0]   readdata;
  logic                                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable, burstcount, debugaccess,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount, debugaccess,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/shmem_resp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read output.
module shmem_resp_ram
  import shmem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/shared_mem_avmm_responder.sv
// Avalon-MM responder owning the HPS/Nios II shared RAM: post-reset clear, 2-cycle reads, byteenable writes.
// Optional write protection of the low window is enabled with `define SHMEM_RESP_WPROT_EN.
module shared_mem_avmm_responder
  import shmem_resp_pkg::*;
#(
  parameter int              ADDR_W      = 18,
  parameter int              DEPTH_LOG2  = 14,
  parameter logic [DATA_W-1:0] INIT_WORD = 32'h0000_0000,
  parameter int unsigned     WPROT_WORDS = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  shared_mem_avmm_responder_if.slave    s0,
  output logic                          init_done,
  output state_e                        dbg_state
`ifdef SHMEM_RESP_WPROT_EN
  ,
  output logic                          wprot_viol
`endif
);

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
  logic                    waitrequest_q, waitrequest_d;
  logic                    init_done_q, init_done_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]       readdata_q, readdata_d;

  logic [ADDR_W-1:0]       addr;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic                    accept_wr, accept_rd, prot_hit;
  logic                    ram_we;
  logic [BE_W-1:0]         ram_be;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_W-1:0]       ram_wdata, ram_rdata;
  logic                    unused_sigs;

  assign addr     = s0.address;
  assign word_idx = DEPTH_LOG2'(addr_to_word(32'(addr), DEPTH_LOG2));

  // A simultaneous read+write performs only the write.
  assign accept_wr = s0.write & ~waitrequest_q;
  assign accept_rd = s0.read & ~s0.write & ~waitrequest_q;

`ifdef SHMEM_RESP_WPROT_EN
  logic wprot_viol_q, wprot_viol_d;
  assign prot_hit     = ~s0.debugaccess & (32'(word_idx) < WPROT_WORDS);
  assign wprot_viol_d = wprot_viol_q | (accept_wr & prot_hit);
  assign wprot_viol   = wprot_viol_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) wprot_viol_q <= 1'b0;
    else                wprot_viol_q <= wprot_viol_d;
  end
`else
  assign prot_hit = 1'b0;
`endif

  assign unused_sigs = &{1'b0, s0.burstcount, s0.debugaccess};

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    waitrequest_d = waitrequest_q;
    init_done_d   = init_done_q;
    case (state_q)
      INIT: begin
        if (&ptr_q) begin
          state_d       = RUN;
          waitrequest_d = 1'b0;
          init_done_d   = 1'b1;
        end else begin
          ptr_d = ptr_q + DEPTH_LOG2'(1);
        end
      end
      RUN: begin
        waitrequest_d = 1'b0;
      end
      default: state_d = INIT;
    endcase
  end

  // The clear sweep owns the RAM port until the FSM reaches RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = s0.byteenable;
    ram_addr  = word_idx;
    ram_wdata = s0.writedata;
    if (state_q == INIT) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = ptr_q;
      ram_wdata = INIT_WORD;
    end else begin
      ram_we = accept_wr & ~prot_hit;
    end
  end

  always_comb begin
    vld_d      = {vld_q[READ_LATENCY-2:0], accept_rd};
    readdata_d = vld_q[0] ? ram_rdata : readdata_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= INIT;
      ptr_q         <= '0;
      waitrequest_q <= 1'b1;
      init_done_q   <= 1'b0;
      vld_q         <= '0;
      readdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      waitrequest_q <= waitrequest_d;
      init_done_q   <= init_done_d;
      vld_q         <= vld_d;
      readdata_q    <= readdata_d;
    end
  end

  shmem_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk_clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign s0.waitrequest   = waitrequest_q;
  assign s0.readdata      = readdata_q;
  assign s0.readdatavalid = vld_q[READ_LATENCY-1];
  assign init_done        = init_done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_shared_mem_avmm_responder.sv
// Directed bench for shared_mem_avmm_responder with a 16-word RAM; covers the protected-window
// behaviour when SHMEM_RESP_WPROT_EN is defined and the unprotected behaviour otherwise.
module tb_shared_mem_avmm_responder;
  import shmem_resp_pkg::*;

  localparam int ADDR_W     = 18;
  localparam int DEPTH_LOG2 = 4;

  logic   clk;
  logic   rst_n;
  logic   init_done;
  state_e dbg_state;
`ifdef SHMEM_RESP_WPROT_EN
  logic   wprot_viol;
`endif

  int errors = 0;
  int checks = 0;

  shared_mem_avmm_responder_if #(.ADDR_W(ADDR_W)) s0_if ();

  shared_mem_avmm_responder #(
    .ADDR_W      (ADDR_W),
    .DEPTH_LOG2  (DEPTH_LOG2),
    .INIT_WORD   (32'h0000_0000),
    .WPROT_WORDS (16)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .s0            (s0_if),
    .init_done     (init_done),
    .dbg_state     (dbg_state)
`ifdef SHMEM_RESP_WPROT_EN
    ,
    .wprot_viol    (wprot_viol)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic idle();
    s0_if.read        = 1'b0;
    s0_if.write       = 1'b0;
    s0_if.address     = '0;
    s0_if.writedata   = '0;
    s0_if.byteenable  = '0;
    s0_if.burstcount  = 1'b1;
    s0_if.debugaccess = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic dbg);
    s0_if.address     = a;
    s0_if.writedata   = d;
    s0_if.byteenable  = be;
    s0_if.debugaccess = dbg;
    s0_if.write       = 1'b1;
    @(negedge clk);
    s0_if.write       = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [17:0] a, input logic [31:0] exp);
    s0_if.address = a;
    s0_if.read    = 1'b1;
    @(negedge clk);
    chk({tag, "_rdv_n1"}, 32'(s0_if.readdatavalid), 32'd0);
    s0_if.read = 1'b0;
    @(negedge clk);
    chk({tag, "_rdv_n2"}, 32'(s0_if.readdatavalid), 32'd1);
    chk({tag, "_data"}, s0_if.readdata, exp);
    @(negedge clk);
    chk({tag, "_rdv_n3"}, 32'(s0_if.readdatavalid), 32'd0);
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    while (s0_if.waitrequest === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  logic [17:0] b2b_addr [4];
  logic [31:0] b2b_exp  [4];

  initial begin
    int cnt;
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_waitrequest", 32'(s0_if.waitrequest), 32'd1);
    chk("rst_rdv", 32'(s0_if.readdatavalid), 32'd0);
    chk("rst_readdata", s0_if.readdata, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(INIT));
`ifdef SHMEM_RESP_WPROT_EN
    chk("rst_wprot_viol", 32'(wprot_viol), 32'd0);
`endif

    // Clear sweep length and contents
    rst_n = 1'b1;
    wait_init(cnt);
    chk("init_len", 32'(cnt), 32'd16);
    chk("init_done", 32'(init_done), 32'd1);
    chk("run_state", 32'(dbg_state), 32'(RUN));
    for (int i = 0; i < 16; i++) begin
      do_read($sformatf("init_word%0d", i), 18'(i * 4), 32'h0000_0000);
    end

    // Byteenable write; 0x40 aliases to word 0 with a 16-word RAM
    do_write(18'h40, 32'hA5A5_5A5A, 4'b0101, 1'b1);
    do_read("be_write", 18'h40, 32'h00A5_005A);

    do_write(18'h04, 32'h1111_1111, 4'b1111, 1'b1);
    do_write(18'h08, 32'h2222_2222, 4'b1111, 1'b1);
    do_write(18'h0C, 32'h3333_3333, 4'b1000, 1'b1);
    do_write(18'h10, 32'h7777_7777, 4'b0000, 1'b1);
    do_read("be_zero_noop", 18'h10, 32'h0000_0000);

    // Back-to-back reads
    b2b_addr[0] = 18'h00; b2b_exp[0] = 32'h00A5_005A;
    b2b_addr[1] = 18'h04; b2b_exp[1] = 32'h1111_1111;
    b2b_addr[2] = 18'h08; b2b_exp[2] = 32'h2222_2222;
    b2b_addr[3] = 18'h0C; b2b_exp[3] = 32'h3300_0000;
    s0_if.address = b2b_addr[0];
    s0_if.read    = 1'b1;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) s0_if.address = b2b_addr[i];
      else       s0_if.read = 1'b0;
      if (i >= 2) begin
        chk($sformatf("b2b_rdv%0d", i - 2), 32'(s0_if.readdatavalid), 32'd1);
        chk($sformatf("b2b_data%0d", i - 2), s0_if.readdata, b2b_exp[i-2]);
      end else begin
        chk("b2b_rdv_early", 32'(s0_if.readdatavalid), 32'd0);
      end
    end
    @(negedge clk);
    chk("b2b_rdv_after", 32'(s0_if.readdatavalid), 32'd0);

    // Write then read of the same word in the next cycle
    do_write(18'h14, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    do_read("wr_then_rd", 18'h14, 32'hDEAD_BEEF);

    // Reset during the sweep at ptr=7 restarts a full sweep
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("sweep_mid_wait", 32'(s0_if.waitrequest), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("sweep_abort_wait", 32'(s0_if.waitrequest), 32'd1);
    chk("sweep_abort_done", 32'(init_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(cnt);
    chk("resweep_len", 32'(cnt), 32'd16);
    do_read("resweep_word0", 18'h00, 32'h0000_0000);
    do_read("resweep_word5", 18'h14, 32'h0000_0000);

    // Simultaneous read and write: write wins, read is dropped
    s0_if.address     = 18'h10;
    s0_if.writedata   = 32'h5555_AAAA;
    s0_if.byteenable  = 4'b1111;
    s0_if.debugaccess = 1'b1;
    s0_if.read        = 1'b1;
    s0_if.write       = 1'b1;
    @(negedge clk);
    s0_if.read  = 1'b0;
    s0_if.write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rdwr_no_rdv%0d", i), 32'(s0_if.readdatavalid), 32'd0);
      @(negedge clk);
    end
    do_read("rdwr_data", 18'h10, 32'h5555_AAAA);

    // Reset while a read is in flight drops its response
    s0_if.address = 18'h10;
    s0_if.read    = 1'b1;
    @(negedge clk);
    s0_if.read = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst_inflight_rdv", 32'(s0_if.readdatavalid), 32'd0);
    @(negedge clk);
    chk("rst_inflight_rdv2", 32'(s0_if.readdatavalid), 32'd0);
    chk("rst_inflight_data", s0_if.readdata, 32'd0);
    rst_n = 1'b1;
    wait_init(cnt);
    chk("third_sweep_len", 32'(cnt), 32'd16);

    // Low-window write with debugaccess=0
    do_write(18'h00, 32'h0000_1234, 4'b1111, 1'b0);
`ifdef SHMEM_RESP_WPROT_EN
    chk("wprot_viol_set", 32'(wprot_viol), 32'd1);
    do_read("wprot_blocked", 18'h00, 32'h0000_0000);
    do_write(18'h00, 32'h0000_1234, 4'b1111, 1'b1);
    do_read("wprot_debug_wr", 18'h00, 32'h0000_1234);
    chk("wprot_viol_sticky", 32'(wprot_viol), 32'd1);
    do_write(18'h40, 32'hCAFE_0000, 4'b1100, 1'b1);
    do_write(18'h44, 32'h0000_0099, 4'b1111, 1'b0);
    do_read("wprot_word1_blocked", 18'h04, 32'h0000_0000);
`else
    do_read("noprot_write", 18'h00, 32'h0000_1234);
    do_write(18'h44, 32'h0000_0099, 4'b1111, 1'b0);
    do_read("noprot_word1", 18'h04, 32'h0000_0099);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
